// File: rtl/gf_syndrome_acc.sv
// Parallel GF(2^M) syndrome accumulator: Horner evaluation of a received codeword
// at alpha^1..alpha^LANES, with a valid/ready result handshake to the key-equation solver.
module gf_syndrome_acc #(
    parameter int             M     = 5,
    parameter logic [M-1:0]   POLY  = 5'b00101,
    parameter int             LANES = 4,
    parameter int             N_SYM = 31,
    parameter int             CW    = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [M-1:0]         sym_in,
    input  logic                 sym_valid,
    input  logic                 sym_first,
    input  logic                 sym_last,
    output logic                 sym_ready,
    output logic [LANES*M-1:0]   synd_out,
    output logic                 synd_valid,
    input  logic                 synd_ready,
    output logic                 synd_zero,
    output logic                 len_err
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t state, state_next;

    logic [LANES-1:0][M-1:0] acc, acc_next;
    logic [CW-1:0]           count, count_inc, count_next;
    logic                    accept, start, step, load, done, release_hs;

    // Multiply by x, reducing by the primitive polynomial (x^M is implied).
    function automatic logic [M-1:0] xtime(input logic [M-1:0] a);
        return {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY : '0);
    endfunction

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        logic [M-1:0] t;
        r = '0;
        t = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ t;
            t = xtime(t);
        end
        return r;
    endfunction

    function automatic logic [M-1:0] alpha_pow(input int e);
        logic [M-1:0] p;
        p = M'(1);
        for (int i = 0; i < e; i++) p = xtime(p);
        return p;
    endfunction

    assign accept     = sym_valid && sym_ready;
    assign start      = accept && sym_first;
    assign step       = accept && !sym_first && (state == ACC);
    assign load       = start || step;
    assign done       = load && sym_last;
    assign release_hs = synd_valid && synd_ready;

    // A first-flagged symbol always restarts, discarding any partial frame.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam logic [M-1:0] ALPHA = alpha_pow(l + 1);
        assign acc_next[l] = start ? sym_in : (gf_mul(acc[l], ALPHA) ^ sym_in);
    end

    assign count_inc  = (count == {CW{1'b1}}) ? count : count + 1'b1;
    assign count_next = start ? CW'(1) : count_inc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACC: if (load) state_next = done ? HOLD : ACC;
            HOLD:      if (synd_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        sym_ready  = (state != HOLD);
        synd_valid = (state == HOLD);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            count     <= '0;
            synd_out  <= '0;
            synd_zero <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            if (load) begin
                acc   <= acc_next;
                count <= count_next;
            end else if (release_hs) begin
                acc   <= '0;
                count <= '0;
            end
            // Results are captured once per frame and held through the handshake.
            if (done) begin
                synd_out  <= acc_next;
                synd_zero <= (acc_next == '0);
                len_err   <= (count_next != CW'(N_SYM));
            end
        end
    end

endmodule
